mprj_wb_mailbox: RTL and testbench
==================================

// Module: mprj_wb_mailbox
// PURPOSE
//  Wishbone classic responder in the user project area; terminates the mgmt core's exported
//  mprj_* master bus. Provides a CPU->user TX FIFO, a user->CPU RX FIFO, status/control
//  registers, and one interrupt line that feeds one bit of the mgmt irq[5:0] input.
//  Single clock domain (core_clk). Both FIFOs are built from flops.
// PARAMETERS
//  BASE_ADR  32'h3000_0000  window base; hit when mprj_adr_o[31:4] == BASE_ADR[31:4]
//  DEPTH     8              entries per FIFO; power of 2, range 2..128
// PORTS
//  core_clk    in   1   clock
//  core_rstn   in   1   async active-low reset
//  wb_cyc_i    in   1   from mprj_cyc_o
//  wb_stb_i    in   1   from mprj_stb_o
//  wb_we_i     in   1   from mprj_we_o
//  wb_sel_i    in   4   from mprj_sel_o
//  wb_adr_i    in   32  from mprj_adr_o
//  wb_dat_i    in   32  from mprj_dat_o
//  wb_ack_o    out  1   to mprj_ack_i
//  wb_dat_o    out  32  to mprj_dat_i
//  tx_data     out  32  TX FIFO head
//  tx_valid    out  1   TX FIFO not empty
//  tx_ready    in   1   user pops TX when tx_valid & tx_ready
//  rx_data     in   32  user write data
//  rx_valid    in   1   user pushes RX when rx_valid & rx_ready
//  rx_ready    out  1   RX FIFO not full
//  irq_o       out  1   level interrupt to the mgmt core
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_dat_o=0, irq_o=0, FIFOs empty (tx_valid=0, rx_ready=1),
//   CTRL=0, sticky flags=0.
//  Access: starts at edge N when cyc&stb&hit&!wb_ack_o. wb_ack_o=1 for exactly cycle N+1.
//   wb_dat_o is valid with ack. FIFO push/pop side effects take effect at edge N.
//   Accesses with no hit are ignored and get no ack. wb_dat_o returns to 0 when ack is low.
//  Map (byte offset adr[3:2]):
//   0x0 TX   W: push wb_dat_i when sel!=0. R: 0.
//   0x4 RX   R: pop, returning the head. W: ignored.
//   0x8 STAT R: [0]tx_full [1]tx_empty [2]rx_full [3]rx_empty [4]tx_ovf [5]rx_unf
//            [15:8]tx_count [23:16]rx_count, zero-extended. W: W1C on [5:4] when sel[0]=1.
//   0xC CTRL RW: [0]rx_ie [1]err_ie. Bits [2]tx_flush and [3]rx_flush are self-clearing
//            and read back 0. Byte lane sel[0] gates the write.
//  Boundaries:
//   - TX write while full: data dropped, tx_ovf set, still acked.
//   - RX read while empty: returns 32'h0, rx_unf set, pointers unchanged.
//   - rx_ready depends only on the current count. A concurrent CPU pop does not admit a
//     push into a full FIFO.
//   - Push and pop in the same cycle on a non-empty/non-full FIFO: count unchanged, both
//     complete.
//   - Flush: pointers and count go to 0 at the write edge. It overrides a same-cycle user
//     push or pop on that FIFO, and does not clear the sticky flags.
//   - Pointers wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits wide.
//  irq_o (registered, 1-cycle latency) = (rx_ie & ~rx_empty) | (err_ie & (tx_ovf|rx_unf)).
//  Reset asserted mid-access: ack drops immediately and the FIFOs empty. The master must
//   restart the access.
// TESTING
//  1. Write 0x3000_0000 = 0xA5A5_0001, tx_ready=0 -> ack 1 cycle later; tx_valid=1,
//     tx_data=0xA5A5_0001; STAT[15:8]=1.
//  2. Write 9 words into TX with DEPTH=8 -> 9 acks, tx_full=1, tx_ovf=1; drain gives
//     words 1..8 in order.
//  3. Read RX while empty -> data 0, rx_unf=1. Write STAT=0x20 -> rx_unf=0.
//  4. CTRL=0x1, user pushes 0x1234 -> irq_o=1. CPU reads 0x3000_0004 -> 0x1234;
//     irq_o=0 one cycle after the pop.
//  5. With RX full, CPU pop and rx_valid in the same cycle -> push refused, count=DEPTH-1,
//     next cycle rx_ready=1.
//  6. stb held with adr=0x3000_0010 -> no ack. core_rstn pulsed low mid-access ->
//     ack=0, FIFOs empty.

Source files
------------

// File: rtl/mprj_wb_mailbox.sv
// mprj_wb_mailbox: Wishbone classic responder for the mgmt core's mprj_* bus.
//   Window of four 32-bit registers at BASE_ADR:
//     0x0 TX   (W push)       0x4 RX  (R pop)
//     0x8 STAT (R, W1C [5:4]) 0xC CTRL (RW ie bits, self-clearing flush bits)
//   Ports:
//     core_clk/core_rstn          clock, async active-low reset
//     wb_*_i / wb_ack_o/wb_dat_o   Wishbone slave side (one-cycle registered ack)
//     tx_data/tx_valid/tx_ready    CPU->user FIFO drain (valid/ready)
//     rx_data/rx_valid/rx_ready    user->CPU FIFO fill (valid/ready)
//     irq_o                        registered level interrupt
//   mprj_wb_mailbox_fifo: flop-based FIFO with flush, used for both directions.

module mprj_wb_mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,   // caller guarantees !o_full
  input  logic                     i_pop,    // caller guarantees !o_empty
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;

  // Storage needs no reset; contents are only observed behind the count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  // Flush wins over any same-cycle push/pop. Pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (i_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
endmodule

module mprj_wb_mailbox #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          DEPTH    = 8
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          r_ack, r_irq;
  logic [31:0]   r_dat;
  logic          r_rx_ie, r_err_ie, r_tx_ovf, r_rx_unf;

  logic          w_hit, w_acc, w_wr, w_rd;
  logic [1:0]    w_off;
  logic          w_tx_wr, w_tx_push, w_tx_pop, w_tx_flush, w_tx_full, w_tx_empty;
  logic          w_rx_rd, w_rx_pop, w_rx_push, w_rx_flush, w_rx_full, w_rx_empty;
  logic          w_ctrl_wr, w_stat_wr;
  logic [CW-1:0] w_tx_cnt, w_rx_cnt;
  logic [31:0]   w_rx_head, w_rdata;
  logic          w_unused;

  assign w_unused = ^wb_adr_i[1:0];

  // An access is taken once; the registered ack itself blocks a re-trigger
  // while the master still holds stb in the ack cycle.
  assign w_hit = (wb_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_acc = wb_cyc_i & wb_stb_i & w_hit & ~r_ack;
  assign w_wr  = w_acc & wb_we_i;
  assign w_rd  = w_acc & ~wb_we_i;
  assign w_off = wb_adr_i[3:2];

  assign w_tx_wr    = w_wr & (w_off == 2'd0) & (|wb_sel_i);
  assign w_tx_push  = w_tx_wr & ~w_tx_full;
  assign w_tx_pop   = tx_valid & tx_ready;
  assign w_rx_rd    = w_rd & (w_off == 2'd1);
  assign w_rx_pop   = w_rx_rd & ~w_rx_empty;
  assign w_rx_push  = rx_valid & rx_ready;
  assign w_stat_wr  = w_wr & (w_off == 2'd2) & wb_sel_i[0];
  assign w_ctrl_wr  = w_wr & (w_off == 2'd3) & wb_sel_i[0];
  assign w_tx_flush = w_ctrl_wr & wb_dat_i[2];
  assign w_rx_flush = w_ctrl_wr & wb_dat_i[3];

  mprj_wb_mailbox_fifo #(.DEPTH(DEPTH), .W(32)) u_tx (
    .clk(core_clk), .rst_n(core_rstn), .i_flush(w_tx_flush),
    .i_push(w_tx_push), .i_pop(w_tx_pop), .i_data(wb_dat_i),
    .o_head(tx_data), .o_cnt(w_tx_cnt), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  // rx_ready comes from the count alone, so a same-cycle CPU pop never
  // opens room for a push into a full FIFO.
  mprj_wb_mailbox_fifo #(.DEPTH(DEPTH), .W(32)) u_rx (
    .clk(core_clk), .rst_n(core_rstn), .i_flush(w_rx_flush),
    .i_push(w_rx_push), .i_pop(w_rx_pop), .i_data(rx_data),
    .o_head(w_rx_head), .o_cnt(w_rx_cnt), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  assign tx_valid = ~w_tx_empty;
  assign rx_ready = ~w_rx_full;

  always_comb begin
    w_rdata = '0;
    case (w_off)
      2'd1:    w_rdata = w_rx_empty ? 32'h0 : w_rx_head;
      2'd2:    w_rdata = {8'd0, 8'(w_rx_cnt), 8'(w_tx_cnt), 2'd0, r_rx_unf, r_tx_ovf,
                          w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
      2'd3:    w_rdata = {30'd0, r_err_ie, r_rx_ie};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq    <= 1'b0;
      r_rx_ie  <= 1'b0;
      r_err_ie <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : 32'h0;
      r_irq <= (r_rx_ie & ~w_rx_empty) | (r_err_ie & (r_tx_ovf | r_rx_unf));
      if (w_ctrl_wr) begin
        r_rx_ie  <= wb_dat_i[0];
        r_err_ie <= wb_dat_i[1];
      end
      // Set and W1C never coincide: they decode from different offsets.
      r_tx_ovf <= (r_tx_ovf & ~(w_stat_wr & wb_dat_i[4])) | (w_tx_wr & w_tx_full);
      r_rx_unf <= (r_rx_unf & ~(w_stat_wr & wb_dat_i[5])) | (w_rx_rd & w_rx_empty);
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;
endmodule

// File: tb/tb_mprj_wb_mailbox.sv
// Self-checking bench for mprj_wb_mailbox: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_mprj_wb_mailbox;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        core_clk = 1'b0, core_rstn = 1'b0;
  logic        wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
  logic [3:0]  wb_sel_i = 0;
  logic [31:0] wb_adr_i = 0, wb_dat_i = 0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o, tx_data;
  logic        tx_valid, tx_ready = 0;
  logic [31:0] rx_data = 0;
  logic        rx_valid = 0, rx_ready, irq_o;

  mprj_wb_mailbox #(.BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq_o(irq_o)
  );

  always #5 core_clk = ~core_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: plain queues and flags.
  logic [31:0] txq[$], rxq[$];
  bit          m_ovf, m_unf, m_rxie, m_errie, m_ack, m_irq;
  logic [31:0] m_dat;

  function automatic void model_reset();
    txq.delete(); rxq.delete();
    m_ovf = 0; m_unf = 0; m_rxie = 0; m_errie = 0; m_ack = 0; m_irq = 0; m_dat = 0;
  endfunction

  // One clock: drive inputs, predict the effects of this edge, then check.
  task automatic step(input bit cyc, input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input bit trdy, input bit rvld, input logic [31:0] rdat);
    bit acc, txfull, rxempty, nirq;
    logic [1:0]  off;
    logic [31:0] rd;
    wb_cyc_i = cyc; wb_stb_i = cyc; wb_we_i = we; wb_adr_i = adr;
    wb_dat_i = dat; wb_sel_i = sel; tx_ready = trdy; rx_valid = rvld; rx_data = rdat;

    acc     = cyc && (adr[31:4] == BASE[31:4]) && !m_ack;
    off     = adr[3:2];
    txfull  = (txq.size() == DEPTH);
    rxempty = (rxq.size() == 0);
    nirq    = (m_rxie && !rxempty) || (m_errie && (m_ovf || m_unf));
    rd = 0;
    if (acc && !we) begin
      case (off)
        2'd1: rd = rxempty ? 32'h0 : rxq[0];
        2'd2: rd = {8'd0, 8'(rxq.size()), 8'(txq.size()), 2'd0, m_unf, m_ovf,
                    rxempty, rxq.size() == DEPTH, txq.size() == 0, txfull};
        2'd3: rd = {30'd0, m_errie, m_rxie};
        default: rd = 0;
      endcase
    end
    if (trdy && txq.size() != 0) void'(txq.pop_front());
    if (acc && we && off == 2'd0 && sel != 0) begin
      if (txfull) m_ovf = 1; else txq.push_back(dat);
    end
    if (rvld && rxq.size() == DEPTH) begin end
    begin
      bit rpush;
      rpush = rvld && (rxq.size() < DEPTH);
      if (acc && !we && off == 2'd1) begin
        if (rxempty) m_unf = 1; else void'(rxq.pop_front());
      end
      if (rpush) rxq.push_back(rdat);
    end
    if (acc && we && off == 2'd2 && sel[0]) begin
      if (dat[4]) m_ovf = 0;
      if (dat[5]) m_unf = 0;
    end
    if (acc && we && off == 2'd3 && sel[0]) begin
      m_rxie = dat[0]; m_errie = dat[1];
      if (dat[2]) txq.delete();
      if (dat[3]) rxq.delete();
    end
    m_ack = acc;
    m_dat = (acc && !we) ? rd : 32'h0;
    m_irq = nirq;

    @(posedge core_clk); #1;
    chk("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
    chk("dat", wb_dat_o, m_dat);
    chk("irq", {31'd0, irq_o}, {31'd0, m_irq});
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, txq.size() != 0});
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_ready", {31'd0, rx_ready}, {31'd0, rxq.size() < DEPTH});
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    step(1, 1, adr, dat, 4'hF, 0, 0, 0); idle();
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] got);
    step(1, 0, adr, 0, 4'hF, 0, 0, 0); got = wb_dat_o; idle();
  endtask

  task automatic push_user(input logic [31:0] d); step(0, 0, 0, 0, 0, 0, 1, d); endtask

  logic [31:0] v;

  initial begin
    model_reset();
    repeat (2) @(posedge core_clk);
    #1;
    chk("rst_ack", {31'd0, wb_ack_o}, 0);
    chk("rst_txv", {31'd0, tx_valid}, 0);
    chk("rst_rxr", {31'd0, rx_ready}, 1);
    chk("rst_irq", {31'd0, irq_o}, 0);
    core_rstn = 1;
    idle();
    rd(BASE + 8, v);
    chk("rst_stat", v, 32'h0000_000A);

    // 1. single TX push
    wr(BASE, 32'hA5A5_0001);
    chk("t1_txd", tx_data, 32'hA5A5_0001);
    rd(BASE + 8, v);
    chk("t1_cnt", {24'd0, v[15:8]}, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0);   // drain it

    // 2. overfill TX, then drain in order
    for (int i = 1; i <= 9; i++) wr(BASE, i);
    rd(BASE + 8, v);
    chk("t2_full", {31'd0, v[0]}, 1);
    chk("t2_ovf", {31'd0, v[4]}, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", tx_data, i);
      step(0, 0, 0, 0, 0, 1, 0, 0);
    end
    wr(BASE + 8, 32'h10);

    // 3. RX underflow and W1C
    rd(BASE + 4, v);
    chk("t3_rd0", v, 0);
    rd(BASE + 8, v);
    chk("t3_unf", {31'd0, v[5]}, 1);
    wr(BASE + 8, 32'h20);
    rd(BASE + 8, v);
    chk("t3_clr", {31'd0, v[5]}, 0);

    // 4. rx interrupt
    wr(BASE + 12, 32'h1);
    push_user(32'h1234);
    idle();
    chk("t4_irq1", {31'd0, irq_o}, 1);
    step(1, 0, BASE + 4, 0, 4'hF, 0, 0, 0);
    chk("t4_pop", wb_dat_o, 32'h1234);
    idle();
    chk("t4_irq0", {31'd0, irq_o}, 0);
    wr(BASE + 12, 32'h0);

    // 5. RX full: CPU pop and user push together
    for (int i = 0; i < DEPTH; i++) push_user(32'hB000 + i);
    chk("t5_full", {31'd0, rx_ready}, 0);
    step(1, 0, BASE + 4, 0, 4'hF, 0, 1, 32'hDEAD);
    chk("t5_head", wb_dat_o, 32'hB000);
    chk("t5_rdy", {31'd0, rx_ready}, 1);
    idle();
    rd(BASE + 8, v);
    chk("t5_cnt", {24'd0, v[23:16]}, DEPTH - 1);
    wr(BASE + 12, 32'hC);           // flush both

    // 6. no-hit address, then reset mid-access
    for (int i = 0; i < 3; i++) begin
      step(1, 0, BASE + 32'h10, 0, 4'hF, 0, 0, 0);
      chk("t6_noack", {31'd0, wb_ack_o}, 0);
    end
    wr(BASE, 32'h77);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = BASE; wb_dat_i = 32'h88; wb_sel_i = 4'hF;
    @(posedge core_clk); #1;
    chk("t6_ack", {31'd0, wb_ack_o}, 1);
    core_rstn = 0; #1;
    chk("t6_rack", {31'd0, wb_ack_o}, 0);
    chk("t6_rtxv", {31'd0, tx_valid}, 0);
    chk("t6_rrxr", {31'd0, rx_ready}, 1);
    wb_cyc_i = 0; wb_stb_i = 0;
    model_reset();
    @(posedge core_clk); #1;
    core_rstn = 1;
    idle();

    // Randomized traffic in phases biased toward filling or draining.
    for (int ph = 0; ph < 6; ph++) begin
      for (int n = 0; n < 300; n++) begin
        logic [31:0] a, d;
        logic [3:0]  s;
        int r;
        r = $urandom_range(0, 11);
        case (r)
          0, 1, 2: a = BASE;
          3, 4:    a = BASE + 4;
          5, 6:    a = BASE + 8;
          7, 8:    a = BASE + 12;
          9:       a = BASE + 32'h10 + ($urandom_range(0, 3) << 2);
          default: a = 32'h2000_0000 + $urandom_range(0, 15);
        endcase
        d = $urandom;
        if (a == BASE + 12 && $urandom_range(0, 7) != 0) d[3:2] = 2'b00;
        s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
        step($urandom_range(0, 1), $urandom_range(0, 1), a, d, s,
             (ph % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
             (ph % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
             $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
